// File: rtl/instr_seq_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit mini-CPU: owns the PC and IR,
// drives the register-file strobes and the data-memory request/ack handshake.
module instr_seq_ctrl #(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            start,
  input  logic            step_mode,
  output logic [PC_W-1:0] instr_addr,
  input  logic [7:0]      instruction,
  output logic            rf_we,
  output logic [1:0]      rf_waddr,
  output logic [1:0]      rf_raddr,
  output logic            rf_wsel,
  output logic [3:0]      imm,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [3:0]      dmem_addr,
  input  logic            dmem_ack,
  output logic            busy,
  output logic            halted,
  output logic            fault,
  output logic [7:0]      retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_WB,
    S_PAUSE,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    OP_LDI   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_STOP  = 2'b11
  } op_t;

  // Counter value seen in the last permitted MEM cycle without an ack.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t          state, state_nx;
  logic [PC_W-1:0] pc;
  logic [7:0]      ir;
  logic [7:0]      tcnt;
  logic [7:0]      ret_cnt;
  logic            fault_q;
  logic            retire;
  logic            set_fault;
  op_t             op;
  state_t          after_retire;

  assign op           = op_t'(ir[7:6]);
  assign after_retire = step_mode ? S_PAUSE : S_FETCH;

  always_comb begin
    state_nx  = state;
    rf_we     = 1'b0;
    rf_wsel   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    retire    = 1'b0;
    set_fault = 1'b0;
    case (state)
      S_IDLE, S_PAUSE: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        busy = 1'b1;
        case (op)
          OP_LDI: begin
            rf_we    = 1'b1;
            retire   = 1'b1;
            state_nx = after_retire;
          end
          OP_LOAD, OP_STORE: state_nx = S_MEM;
          default:           state_nx = S_HALT;
        endcase
      end
      S_MEM: begin
        busy     = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = (op == OP_STORE);
        // Ack wins over timeout, so an ack on the final permitted cycle is accepted.
        if (dmem_ack) begin
          if (op == OP_STORE) begin
            retire   = 1'b1;
            state_nx = after_retire;
          end else begin
            state_nx = S_WB;
          end
        end else if (tcnt == TMO_LAST) begin
          set_fault = 1'b1;
          state_nx  = S_HALT;
        end
      end
      S_WB: begin
        busy     = 1'b1;
        rf_we    = 1'b1;
        rf_wsel  = 1'b1;
        retire   = 1'b1;
        state_nx = after_retire;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      tcnt    <= '0;
      ret_cnt <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH) begin
        ir <= instruction;
        pc <= pc + PC_W'(1);
      end
      if (state == S_MEM) tcnt <= tcnt + 8'd1;
      else                tcnt <= '0;
      if (retire && ret_cnt != '1) ret_cnt <= ret_cnt + 8'd1;
      if (set_fault) fault_q <= 1'b1;
    end
  end

  assign instr_addr = pc;
  assign rf_waddr   = ir[1:0];
  assign rf_raddr   = ir[1:0];
  assign imm        = ir[5:2];
  assign dmem_addr  = ir[5:2];
  assign fault      = fault_q;
  assign retired    = ret_cnt;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Bench for instr_seq_ctrl: instruction-level reference model compared every
// cycle, directed scenarios with literal expectations, then random programs.
module tb_instr_seq_ctrl;
  localparam int PC_W = 8;
  localparam int TMO  = 15;
  localparam int NOACK = 999;

  logic            clk = 1'b0;
  logic            clear = 1'b0, start = 1'b0, step_mode = 1'b0, dmem_ack = 1'b0;
  logic [PC_W-1:0] instr_addr;
  logic [7:0]      instruction;
  logic            rf_we, rf_wsel, dmem_req, dmem_we, busy, halted, fault;
  logic [1:0]      rf_waddr, rf_raddr;
  logic [3:0]      imm, dmem_addr;
  logic [7:0]      retired;

  logic [7:0] rom [256];
  assign instruction = rom[instr_addr];

  instr_seq_ctrl #(.PC_W(PC_W), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .clear(clear), .start(start), .step_mode(step_mode),
    .instr_addr(instr_addr), .instruction(instruction),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_raddr(rf_raddr), .rf_wsel(rf_wsel),
    .imm(imm), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_ack(dmem_ack), .busy(busy), .halted(halted), .fault(fault),
    .retired(retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the instruction in flight by its cycle index
  // (0 = fetch, 1 = decode, 2.. = memory wait) plus a write-back flag.
  bit         chk_en = 0;
  bit         m_act = 0, m_halt = 0, m_fault = 0, m_wb = 0;
  int         m_t = 0, m_pc = 0, m_ret = 0;
  logic [7:0] m_ir = '0;

  task automatic m_retire();
    if (m_ret < 255) m_ret++;
  endtask

  task automatic m_next();
    m_wb = 0;
    if (step_mode) m_act = 0;
    else           m_t = 0;
  endtask

  always @(posedge clk) begin
    if (clear) begin
      m_act = 0; m_halt = 0; m_fault = 0; m_wb = 0;
      m_t = 0; m_pc = 0; m_ret = 0; m_ir = '0; chk_en = 1;
    end else if (m_halt) begin
      // only clear leaves a halt
    end else if (!m_act) begin
      if (start) begin m_act = 1; m_t = 0; m_wb = 0; end
    end else if (m_wb) begin
      m_retire(); m_next();
    end else if (m_t == 0) begin
      m_ir = rom[m_pc];
      m_pc = (m_pc + 1) % 256;
      m_t  = 1;
    end else if (m_t == 1) begin
      case (m_ir[7:6])
        2'd0: begin m_retire(); m_next(); end
        2'd3: begin m_halt = 1; m_act = 0; end
        default: m_t = 2;
      endcase
    end else begin
      if (dmem_ack) begin
        if (m_ir[7:6] == 2'd2) begin m_retire(); m_next(); end
        else m_wb = 1;
      end else if (m_t - 1 == TMO) begin
        m_fault = 1; m_halt = 1; m_act = 0;
      end else begin
        m_t++;
      end
    end
  end

  always @(negedge clk) begin
    logic [34:0] act, exp;
    logic e_rfwe, e_wsel, e_req, e_we;
    if (chk_en) begin
      e_rfwe = m_act && (m_wb || (m_t == 1 && m_ir[7:6] == 2'd0));
      e_wsel = m_act && m_wb;
      e_req  = m_act && m_t >= 2 && !m_wb;
      e_we   = e_req && m_ir[7:6] == 2'd2;
      exp = {m_act, m_halt, m_fault, 8'(m_pc), 8'(m_ret), e_rfwe, m_ir[1:0], m_ir[1:0],
             e_wsel, m_ir[5:2], e_req, e_we, m_ir[5:2]};
      act = {busy, halted, fault, instr_addr, retired, rf_we, rf_waddr, rf_raddr,
             rf_wsel, imm, dmem_req, dmem_we, dmem_addr};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL outputs t=%0t: got %h expected %h", $time, act, exp);
      end
    end
  end

  // Data-memory responder: acks after a per-request delay (1 = same cycle).
  int force_delay = 0;
  int rcnt = 0, rdelay = 1;
  int req_cycles = 0;

  always @(posedge clk) begin
    #1;
    if (dmem_req === 1'b1) begin
      rcnt++;
      dmem_ack = (rcnt == rdelay);
    end else begin
      int r;
      rcnt = 0;
      dmem_ack = 1'b0;
      r = $urandom_range(0, 19);
      if (force_delay != 0) rdelay = force_delay;
      else if (r == 0)      rdelay = NOACK;
      else if (r == 1)      rdelay = TMO;
      else if (r == 2)      rdelay = TMO + 1;
      else                  rdelay = $urandom_range(1, 4);
    end
  end

  always @(negedge clk) if (dmem_req === 1'b1) req_cycles++;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(1); clear = 1'b0;
    req_cycles = 0;
  endtask

  task automatic fill_stop();
    for (int i = 0; i < 256; i++) rom[i] = 8'hC0;
  endtask

  task automatic wait_halt(input int budget);
    int k = 0;
    while (halted !== 1'b1 && k < budget) begin tick(1); k++; end
    chk("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic run_single(input logic [7:0] ins, input int delay);
    fill_stop();
    rom[0] = ins;
    force_delay = delay;
    do_clear();
    start = 1'b1; tick(1); start = 1'b0;
    wait_halt(40);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hcnt;
    fill_stop();
    tick(1);

    // LDI r1,#2 then STOP
    rom[0] = 8'b00001001; rom[1] = 8'b11000011;
    do_clear();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_retired", {24'd0, retired}, 0);
    chk("rst_addr", {24'd0, instr_addr}, 0);
    chk("rst_req", {31'd0, dmem_req}, 0);
    start = 1'b1;
    tick(2);
    chk("ldi_we", {31'd0, rf_we}, 1);
    chk("ldi_waddr", {30'd0, rf_waddr}, 1);
    chk("ldi_imm", {28'd0, imm}, 2);
    wait_halt(10);
    chk("ldi_retired", {24'd0, retired}, 1);
    chk("ldi_addr", {24'd0, instr_addr}, 2);
    start = 1'b0;

    run_single(8'b01011101, 2);
    chk("load_req_cycles", req_cycles, 2);
    chk("load_retired", {24'd0, retired}, 1);

    fill_stop();
    rom[0] = 8'b10001111; rom[1] = 8'b00000100;
    force_delay = 1;
    do_clear();
    start = 1'b1; tick(1); start = 1'b0;
    wait_halt(20);
    chk("store_req_cycles", req_cycles, 1);
    chk("store_retired", {24'd0, retired}, 2);

    run_single(8'b01011101, TMO);
    chk("late_ack_fault", {31'd0, fault}, 0);
    chk("late_ack_req", req_cycles, TMO);
    chk("late_ack_retired", {24'd0, retired}, 1);

    run_single(8'b01011101, NOACK);
    chk("tmo_req", req_cycles, TMO);
    chk("tmo_fault", {31'd0, fault}, 1);
    chk("tmo_retired", {24'd0, retired}, 0);
    start = 1'b1; tick(5);
    chk("tmo_hold", {31'd0, halted}, 1);
    chk("tmo_nobusy", {31'd0, busy}, 0);
    do_clear();
    chk("tmo_clr_fault", {31'd0, fault}, 0);
    chk("tmo_clr_halt", {31'd0, halted}, 0);
    start = 1'b0;

    fill_stop();
    rom[0] = 8'b00000100; rom[1] = 8'b00001010; rom[2] = 8'b00111111;
    do_clear();
    step_mode = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      int k = 0;
      start = 1'b1; tick(1); start = 1'b0;
      while (busy === 1'b1 && k < 10) begin tick(1); k++; end
      chk("step_retired", {24'd0, retired}, i);
      tick(3);
      chk("step_paused_addr", {24'd0, instr_addr}, i);
    end
    step_mode = 1'b0;

    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 63));
    do_clear();
    start = 1'b1; tick(600); start = 1'b0;
    chk("sat_retired", {24'd0, retired}, 255);
    chk("sat_busy", {31'd0, busy}, 1);

    run_single(8'b01011101, NOACK);
    do_clear();
    start = 1'b1; tick(1); start = 1'b0;
    tick(6);
    chk("mid_mem_req", {31'd0, dmem_req}, 1);
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("mid_clr_req", {31'd0, dmem_req}, 0);
    chk("mid_clr_busy", {31'd0, busy}, 0);

    force_delay = 0;
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 15) == 0) rom[i] = 8'hC0 | 8'($urandom_range(0, 63));
      else rom[i] = {2'($urandom_range(0, 2)), 6'($urandom_range(0, 63))};
    end
    do_clear();
    hcnt = 0;
    for (int c = 0; c < 4000; c++) begin
      hcnt = (halted === 1'b1) ? hcnt + 1 : 0;
      start     = ($urandom_range(0, 3) != 0);
      step_mode = ($urandom_range(0, 7) == 0);
      clear     = (hcnt > 3) || ($urandom_range(0, 499) == 0);
      tick(1);
    end
    clear = 1'b0; start = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
